// File: rtl/apb_master_ctrl_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths
// and the timeout counter width helper.
package apb_master_ctrl_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Counter is never narrower than 8 bits so the limit can be raised later.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command/response handshake plus APB bus signals of the requester.
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // cmd_* and rsp_* are valid/ready channels: a beat transfers on the rising
  // clock edge where valid && ready; the producer holds valid and payload stable
  // until that edge and never withdraws valid before the transfer.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );

endinterface

// File: rtl/apb_master_ctrl_timeout_cnt.sv
// ACCESS-phase wait counter: cleared before each ACCESS phase, counts cycles
// spent waiting for pready and flags the LIMIT-th consecutive wait cycle.
module apb_master_ctrl_timeout_cnt
  import apb_master_ctrl_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);
  localparam logic [CW-1:0] LAST_V  = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // cnt_q holds completed wait cycles, so this cycle is wait number cnt_q+1.
  assign expired_o = en_i && (cnt_q == LAST_V);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: one SETUP/ACCESS transfer per accepted command, result returned
// on a valid/ready response port. Optional ACCESS timeout: APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               pclk,
  input  logic               rst,
  apb_master_ctrl_if.master  bus,
  output state_t             state_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              tmo_expired;

`ifdef APB_MASTER_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  // SETUP always precedes ACCESS, so clearing there gives a fresh count.
  assign tmo_clr = (state_q == ST_SETUP);
  assign tmo_en  = (state_q == ST_ACCESS) && !bus.pready;

  apb_master_ctrl_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (pclk),
    .rst_i     (rst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over an expiry on the same edge.
        if (bus.pready || tmo_expired) begin
          rsp_rdata_d = (bus.pready && !pwrite_q) ? bus.prdata : '0;
          rsp_err_d   = !bus.pready;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: vector table of single transfers plus
// hand-written back-to-back and mid-transfer reset sequences, APB protocol watch.
module tb_apb_master_ctrl;
  import apb_master_ctrl_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic   pclk;
  logic   rst;
  state_t state;

  apb_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_ctrl #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk    (pclk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_acc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  // ---------------- protocol watch ----------------
  logic          prev_psel, prev_penable, prev_pwrite;
  logic [AW-1:0] prev_paddr;
  logic [DW-1:0] prev_pwdata;
  logic          proto_ok;

  always @(negedge pclk) begin
    if (!rst) begin
      proto_ok = 1'b1;
      if (bus.penable && !bus.psel) proto_ok = 1'b0;
      if (bus.penable && !prev_psel) proto_ok = 1'b0;
      if (bus.psel && prev_psel &&
          (bus.paddr !== prev_paddr || bus.pwrite !== prev_pwrite || bus.pwdata !== prev_pwdata))
        proto_ok = 1'b0;
      checks++;
      if (!proto_ok) begin
        errors++;
        $display("FAIL protocol t=%0t psel=%0b penable=%0b paddr=0x%0h prev_psel=%0b prev_paddr=0x%0h",
                 $time, bus.psel, bus.penable, bus.paddr, prev_psel, prev_paddr);
      end
    end
    prev_psel    = bus.psel;
    prev_penable = bus.penable;
    prev_pwrite  = bus.pwrite;
    prev_paddr   = bus.paddr;
    prev_pwdata  = bus.pwdata;
  end

  // ---------------- driver ----------------
  task automatic do_xfer(input vec_t v, input string tag);
    int            edges;
    int            acc;
    int            waits;
    int            c;
    logic          got;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_pwdata;
    exp_pwdata = v.write ? v.wdata : '0;

    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.rsp_ready = 1'b1;
    bus.pready    = 1'b0;
    exp_q.push_back(v.exp_rdata);
    check({tag, ".cmd_ready_idle"}, bus.cmd_ready, 1);

    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    check({tag, ".setup_sel_en"}, {bus.psel, bus.penable}, 2'b10);
    check({tag, ".setup_paddr"}, bus.paddr, v.addr);
    check({tag, ".setup_pwrite"}, bus.pwrite, v.write);
    check({tag, ".setup_pwdata"}, bus.pwdata, exp_pwdata);
    check({tag, ".busy_cmd_ready"}, bus.cmd_ready, 0);

    edges = 1;
    acc   = 0;
    waits = v.waits;
    got   = 1'b0;
    c     = 0;
    while (!got && c < 64) begin
      @(posedge pclk);
      edges++;
      @(negedge pclk);
      c++;
      if (bus.rsp_valid) begin
        got = 1'b1;
      end else if (bus.psel && bus.penable) begin
        acc++;
        if (acc == 1) check({tag, ".access_paddr"}, bus.paddr, v.addr);
        bus.pready = (waits == 0);
        bus.prdata = (waits == 0) ? v.prdata : DW'($urandom);
        if (waits > 0) waits--;
      end
    end
    bus.pready = 1'b0;

    check({tag, ".rsp_valid_seen"}, got, 1);
    if (!got) begin
      apply_reset();
      exp_q.delete();
      return;
    end
    exp_rd = exp_q.pop_front();
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rd);
    check({tag, ".rsp_err"}, bus.rsp_err, v.exp_err);
    check({tag, ".latency"}, edges, 2 + v.exp_acc);
    check({tag, ".access_cycles"}, acc, v.exp_acc);
    check({tag, ".bus_idle"}, {bus.psel, bus.penable, bus.pwrite}, 3'b000);
    check({tag, ".bus_cleared"}, {bus.paddr, bus.pwdata}, 64'h0);

    @(posedge pclk);
    @(negedge pclk);
    check({tag, ".rsp_consumed"}, bus.rsp_valid, 0);
    check({tag, ".back_to_idle"}, bus.cmd_ready, 1);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (!bus.rsp_valid && n < budget) begin
      @(posedge pclk);
      @(negedge pclk);
      n++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int            n;
    logic [DW-1:0] exp_rd;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;

    //          write addr           wdata          waits prdata         exp_rdata      err acc
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'h1234_5678, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4});
    vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h5555_5555, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1});
    vecs.push_back('{1'b1, 32'h1000_0010, 32'h0000_0001, 2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0000, 1'b0, 2});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0, 6});
`ifdef APB_MASTER_TIMEOUT_EN
    vecs.push_back('{1'b0, 32'h0000_0080, 32'h0000_0000, 1000, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, TMO});
    vecs.push_back('{1'b0, 32'h0000_0084, 32'h0000_0000, TMO-1, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0, TMO});
    vecs.push_back('{1'b1, 32'h0000_0088, 32'h1357_9BDF, 1000, 32'h2468_ACE0, 32'h0000_0000, 1'b1, TMO});
`endif

    // Reset values while rst is held.
    @(posedge pclk);
    @(negedge pclk);
    check("rst.state", state, ST_IDLE);
    check("rst.sel_en_wr", {bus.psel, bus.penable, bus.pwrite}, 3'b000);
    check("rst.paddr", bus.paddr, 0);
    check("rst.pwdata", bus.pwdata, 0);
    check("rst.rsp", {bus.rsp_valid, bus.rsp_err}, 2'b00);
    check("rst.rsp_rdata", bus.rsp_rdata, 0);
    rst = 1'b0;
    @(negedge pclk);
    check("rst.cmd_ready_after", bus.cmd_ready, 1);

    foreach (vecs[i]) do_xfer(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back commands with the response held off for 5 cycles.
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0100;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b1;
    bus.prdata    = 32'h1111_2222;
    exp_q.push_back(32'h1111_2222);
    exp_q.push_back(32'h0000_0000);
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0200;
    bus.cmd_wdata = 32'h3333_4444;
    wait_rsp(16, n);
    check("b2b.a_latency", n, 2);
    exp_rd = exp_q.pop_front();
    check("b2b.a_rdata", bus.rsp_rdata, exp_rd);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b.hold%0d_cmd_ready", i), bus.cmd_ready, 0);
      check($sformatf("b2b.hold%0d_psel", i), bus.psel, 0);
      check($sformatf("b2b.hold%0d_rsp", i), {bus.rsp_valid, bus.rsp_rdata}, {1'b1, exp_rd});
      @(posedge pclk);
      @(negedge pclk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("b2b.idle_cmd_ready", bus.cmd_ready, 1);
    check("b2b.idle_psel_rsp", {bus.psel, bus.rsp_valid}, 2'b00);
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    check("b2b.b_setup", {bus.psel, bus.penable, bus.pwrite}, 3'b101);
    check("b2b.b_paddr", bus.paddr, 32'h0000_0200);
    check("b2b.b_pwdata", bus.pwdata, 32'h3333_4444);
    wait_rsp(16, n);
    check("b2b.b_latency", n, 2);
    exp_rd = exp_q.pop_front();
    check("b2b.b_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 1'b0, exp_rd});
    @(posedge pclk);
    @(negedge pclk);
    check("b2b.b_done", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;

    // Reset pulsed while waiting in ACCESS.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0020;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    check("rstx.in_access", state, ST_ACCESS);
    #2;
    rst = 1'b1;
    #1;
    check("rstx.async_drop", {bus.psel, bus.penable}, 2'b00);
    check("rstx.no_rsp", bus.rsp_valid, 0);
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    check("rstx.cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("rstx.quiet%0d", i), {bus.rsp_valid, bus.psel}, 2'b00);
    end

    do_xfer(vecs[1], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog simulation time limit reached at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
